// File: rtl/iter_alu_pkg.sv
// Shared types and constants for the iterative ALU: operation encoding,
// FSM state encoding and datapath width.
package alu_pkg;

   localparam int unsigned XLEN = 32;

   typedef enum logic [3:0] {
      OP_AND = 4'b0000,
      OP_OR  = 4'b0001,
      OP_ADD = 4'b0010,
      OP_SUB = 4'b0011,
      OP_SLL = 4'b0100,
      OP_SRL = 4'b0101,
      OP_XOR = 4'b0110,
      OP_SRA = 4'b0111,
      OP_BEQ = 4'b1000,
      OP_SLT = 4'b1100
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_DONE
   } alu_state_e;

endpackage

// File: rtl/iter_alu_if.sv
// Operand/result handshake bundle of iter_alu; the ALU is the slave side,
// the producer/consumer of operations is the master side.
interface iter_alu_if;
   import alu_pkg::*;

   logic            in_valid;
   logic            in_ready;
   logic [3:0]      Operation;
   logic [XLEN-1:0] SrcA;
   logic [XLEN-1:0] SrcB;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] ALUResult;
   logic            Zero;

   modport master (
      output in_valid, Operation, SrcA, SrcB, out_ready,
      input  in_ready, out_valid, ALUResult, Zero
   );

   modport slave (
      input  in_valid, Operation, SrcA, SrcB, out_ready,
      output in_ready, out_valid, ALUResult, Zero
   );

endinterface

// File: rtl/iter_alu_shift_step.sv
// Single-bit shift step: left shifts insert 0, right shifts insert 0 or,
// for arithmetic shifts, a copy of the current sign bit.
module alu_shift_step
   import alu_pkg::*;
(
   input  logic [XLEN-1:0] i_data,
   input  logic            i_left,
   input  logic            i_arith,
   output logic [XLEN-1:0] o_data
);

   always_comb begin
      if (i_left) begin
         o_data = {i_data[XLEN-2:0], 1'b0};
      end else begin
         o_data = {i_arith & i_data[XLEN-1], i_data[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/iter_alu.sv
// Iterative 32-bit ALU with valid/ready handshakes on both sides.
// Define ITER_ALU_FAST_SHIFT_EN to complete shifts in one cycle (barrel shifter).
module iter_alu
   import alu_pkg::*;
(
   input  logic      clk,
   input  logic      reset,
   iter_alu_if.slave bus
);

`ifdef ITER_ALU_FAST_SHIFT_EN
   localparam logic ITERATIVE = 1'b0;
`else
   localparam logic ITERATIVE = 1'b1;
`endif

   alu_state_e      r_state, w_state_nxt;
   logic [XLEN-1:0] r_work, w_work_nxt;
   logic [4:0]      r_cnt, w_cnt_nxt;
   logic [3:0]      r_op, w_op_nxt;
   logic [XLEN-1:0] r_result, w_result_nxt;
   logic            r_zero, w_zero_nxt;

   logic [4:0]      w_shamt;
   logic            w_is_shift;
   logic [XLEN-1:0] w_alu;
   logic [XLEN-1:0] w_step_in, w_step_out;
   logic [3:0]      w_step_op;

   assign w_shamt    = bus.SrcB[4:0];
   assign w_is_shift = (bus.Operation == OP_SLL) || (bus.Operation == OP_SRL) ||
                       (bus.Operation == OP_SRA);

   always_comb begin
      w_alu = '0;
      case (bus.Operation)
         OP_AND: w_alu = bus.SrcA & bus.SrcB;
         OP_OR:  w_alu = bus.SrcA | bus.SrcB;
         OP_XOR: w_alu = bus.SrcA ^ bus.SrcB;
         OP_ADD: w_alu = bus.SrcA + bus.SrcB;
         OP_SUB,
         OP_BEQ: w_alu = bus.SrcA - bus.SrcB;
         OP_SLT: w_alu = {{(XLEN-1){1'b0}}, $signed(bus.SrcA) < $signed(bus.SrcB)};
`ifdef ITER_ALU_FAST_SHIFT_EN
         OP_SLL: w_alu = bus.SrcA << w_shamt;
         OP_SRL: w_alu = bus.SrcA >> w_shamt;
         OP_SRA: w_alu = $unsigned($signed(bus.SrcA) >>> w_shamt);
`else
         // iterative build: only shamt==0 shifts complete here
         OP_SLL, OP_SRL, OP_SRA: w_alu = bus.SrcA;
`endif
         default: w_alu = '0;
      endcase
   end

   // The first step runs in the accept cycle, so N steps end N cycles after accept
   assign w_step_in = (r_state == ST_IDLE) ? bus.SrcA : r_work;
   assign w_step_op = (r_state == ST_IDLE) ? bus.Operation : r_op;

   alu_shift_step u_step (
      .i_data  (w_step_in),
      .i_left  (w_step_op == OP_SLL),
      .i_arith (w_step_op == OP_SRA),
      .o_data  (w_step_out)
   );

   always_comb begin
      w_state_nxt  = r_state;
      w_work_nxt   = r_work;
      w_cnt_nxt    = r_cnt;
      w_op_nxt     = r_op;
      w_result_nxt = r_result;
      w_zero_nxt   = r_zero;
      case (r_state)
         ST_IDLE: begin
            if (bus.in_valid) begin
               w_op_nxt = bus.Operation;
               if (ITERATIVE && w_is_shift && (w_shamt != 5'd0)) begin
                  if (w_shamt == 5'd1) begin
                     w_result_nxt = w_step_out;
                     w_zero_nxt   = (w_step_out == '0);
                     w_state_nxt  = ST_DONE;
                  end else begin
                     w_work_nxt  = w_step_out;
                     w_cnt_nxt   = w_shamt - 5'd1;
                     w_state_nxt = ST_SHIFT;
                  end
               end else begin
                  w_result_nxt = w_alu;
                  w_zero_nxt   = (w_alu == '0);
                  w_state_nxt  = ST_DONE;
               end
            end
         end
         ST_SHIFT: begin
            w_work_nxt = w_step_out;
            w_cnt_nxt  = r_cnt - 5'd1;
            if (r_cnt == 5'd1) begin
               w_result_nxt = w_step_out;
               w_zero_nxt   = (w_step_out == '0);
               w_state_nxt  = ST_DONE;
            end
         end
         ST_DONE: begin
            if (bus.out_ready) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_work   <= '0;
         r_cnt    <= '0;
         r_op     <= '0;
         r_result <= '0;
         r_zero   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_work   <= w_work_nxt;
         r_cnt    <= w_cnt_nxt;
         r_op     <= w_op_nxt;
         r_result <= w_result_nxt;
         r_zero   <= w_zero_nxt;
      end
   end

   assign bus.in_ready  = (r_state == ST_IDLE);
   assign bus.out_valid = (r_state == ST_DONE);
   assign bus.ALUResult = r_result;
   assign bus.Zero      = r_zero;

endmodule

// File: tb/tb_iter_alu.sv
// Scoreboard bench for iter_alu: expected results are queued at issue and
// popped when out_valid appears; latency follows ITER_ALU_FAST_SHIFT_EN.
module tb_iter_alu;
   import alu_pkg::*;

   typedef struct {
      logic [31:0] res;
      logic        zero;
      int          lat;
   } exp_t;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_errors;
   exp_t sb[$];

   iter_alu_if bus_if ();

   iter_alu dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      logic [4:0] sh;
      sh    = b[4:0];
      e.lat = 1;
      case (op)
         4'b0000: e.res = a & b;
         4'b0001: e.res = a | b;
         4'b0010: e.res = a + b;
         4'b0011: e.res = a - b;
         4'b0100: e.res = a << sh;
         4'b0101: e.res = a >> sh;
         4'b0110: e.res = a ^ b;
         4'b0111: e.res = $unsigned($signed(a) >>> sh);
         4'b1000: e.res = a - b;
         4'b1100: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: e.res = 32'd0;
      endcase
`ifndef ITER_ALU_FAST_SHIFT_EN
      if ((op == 4'b0100 || op == 4'b0101 || op == 4'b0111) && sh != 5'd0) e.lat = int'(sh);
`endif
      e.zero = (e.res == 32'd0);
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one op, wait for its result, hold it for `hold` cycles, then consume
   task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
      exp_t e;
      int   cyc;
      logic busy_bad;
      logic [31:0] held;
      sb.push_back(model(op, a, b));
      check_eq({tag, "_rdy"}, {31'd0, bus_if.in_ready}, 32'd1);
      bus_if.in_valid  = 1'b1;
      bus_if.Operation = op;
      bus_if.SrcA      = a;
      bus_if.SrcB      = b;
      tick();
      // post-accept operand changes and in_valid must be ignored
      bus_if.SrcA      = $urandom;
      bus_if.SrcB      = $urandom;
      bus_if.Operation = 4'b0010;
      cyc      = 1;
      busy_bad = 1'b0;
      while (!bus_if.out_valid && cyc < 100) begin
         if (bus_if.in_ready) busy_bad = 1'b1;
         tick();
         cyc++;
      end
      bus_if.in_valid = 1'b0;
      check_eq({tag, "_busy_rdy"}, {31'd0, busy_bad}, 32'd0);
      e = sb.pop_front();
      check_eq({tag, "_lat"}, cyc, e.lat);
      check_eq({tag, "_res"}, bus_if.ALUResult, e.res);
      check_eq({tag, "_zero"}, {31'd0, bus_if.Zero}, {31'd0, e.zero});
      held = bus_if.ALUResult;
      for (int i = 0; i < hold; i++) begin
         tick();
         check_eq({tag, "_hold_vld"}, {30'd0, bus_if.out_valid, bus_if.in_ready}, 32'd2);
         check_eq({tag, "_hold_res"}, bus_if.ALUResult, held);
      end
      bus_if.out_ready = 1'b1;
      tick();
      bus_if.out_ready = 1'b0;
      check_eq({tag, "_idle"}, {30'd0, bus_if.out_valid, bus_if.in_ready}, 32'd1);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      reset            = 1'b1;
      bus_if.in_valid  = 1'b0;
      bus_if.Operation = '0;
      bus_if.SrcA      = '0;
      bus_if.SrcB      = '0;
      bus_if.out_ready = 1'b0;
      tick();
      tick();
      // reset wins over a coincident accept
      bus_if.in_valid = 1'b1;
      bus_if.SrcA     = 32'h5;
      tick();
      reset           = 1'b0;
      bus_if.in_valid = 1'b0;
      check_eq("rst_vld_rdy", {30'd0, bus_if.out_valid, bus_if.in_ready}, 32'd1);
      check_eq("rst_res", bus_if.ALUResult, 32'd0);
      check_eq("rst_zero", {31'd0, bus_if.Zero}, 32'd0);
      // out_ready with no result pending has no effect
      bus_if.out_ready = 1'b1;
      tick();
      bus_if.out_ready = 1'b0;
      check_eq("oready_idle", {30'd0, bus_if.out_valid, bus_if.in_ready}, 32'd1);

      do_op("add_wrap", 4'b0010, 32'h7FFFFFFF, 32'd1, 0);
      do_op("sra31", 4'b0111, 32'h80000000, 32'd31, 0);
      do_op("beq", 4'b1000, 32'h1234, 32'h1234, 0);
      do_op("slt", 4'b1100, 32'hFFFFFFFF, 32'd1, 0);
      do_op("xor_bp", 4'b0110, 32'hF0F0F0F0, 32'hFFFF0000, 5);
      do_op("sub_wrap", 4'b0011, 32'd0, 32'd1, 0);
      do_op("sll0", 4'b0100, 32'hDEADBEEF, 32'hFFFFFFE0, 0);
      do_op("sll1", 4'b0100, 32'h80000001, 32'd1, 0);
      do_op("srl5", 4'b0101, 32'h80000000, 32'd5, 1);
      do_op("sra_pos", 4'b0111, 32'h40000000, 32'd3, 0);
      do_op("and", 4'b0000, 32'hFF00FF00, 32'h0FF00FF0, 0);
      do_op("or", 4'b0001, 32'h00000000, 32'h00000000, 0);
      do_op("ill_f", 4'b1111, 32'h12345678, 32'h1, 0);
      do_op("ill_9", 4'b1001, 32'hFFFFFFFF, 32'h0, 2);

      // reset in the middle of an SLL by 20
      bus_if.in_valid  = 1'b1;
      bus_if.Operation = 4'b0100;
      bus_if.SrcA      = 32'h1;
      bus_if.SrcB      = 32'd20;
      tick();
      bus_if.in_valid = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_eq("mid_rst_vld_rdy", {30'd0, bus_if.out_valid, bus_if.in_ready}, 32'd1);
      check_eq("mid_rst_res", bus_if.ALUResult, 32'd0);
      begin
         logic seen;
         seen = 1'b0;
         for (int i = 0; i < 30; i++) begin
            tick();
            if (bus_if.out_valid) seen = 1'b1;
         end
         check_eq("mid_rst_no_out", {31'd0, seen}, 32'd0);
      end

      for (int i = 0; i < 12; i++) begin
         logic [3:0] ops[10];
         ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
                 4'b0101, 4'b0110, 4'b0111, 4'b1000, 4'b1100};
         do_op("rnd", ops[$urandom_range(9, 0)], $urandom, $urandom, $urandom_range(2, 0));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
